// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op codes, FSM states and status flag layout for alu_seq_core
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_MUL = 3'b010,
        OP_DIV = 3'b011,
        OP_AND = 3'b100,
        OP_OR  = 3'b101,
        OP_XOR = 3'b110,
        OP_ILL = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_ITER = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    typedef struct packed {
        logic zero;
        logic dz;
        logic ovf;
        logic ill;
    } flags_t;

endpackage

// File: rtl/alu_muldiv_iter.sv
// rtl/alu_muldiv_iter.sv - radix-2 shift-add multiplier / restoring divider on operand magnitudes
module alu_muldiv_iter #(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             is_div,
    input  logic [W-1:0]     mag_a,
    input  logic [W-1:0]     mag_b,
    input  logic             sign_a,
    input  logic             sign_b,
    input  logic             step,
    output logic             fin,
    output logic [2*W-1:0]   res,
    output logic             neg_lo,
    output logic             neg_hi
);

    localparam int CW = $clog2(W);

    logic [CW-1:0]  cnt;
    logic [2*W-1:0] acc;
    logic [W-1:0]   divisor;
    logic           div_q;
    logic [W:0]     add_sum;
    logic [2*W:0]   shl;
    logic [W-1:0]   trial;
    logic           fits;

    // Multiply keeps {partial product, remaining multiplier}; divide keeps {remainder, quotient}.
    assign add_sum = {1'b0, acc[2*W-1:W]} + {1'b0, divisor};
    assign shl     = {acc, 1'b0};
    assign fits    = shl[2*W:W] >= {1'b0, divisor};
    assign trial   = shl[2*W-1:W] - divisor;
    assign fin     = (cnt == CW'(W - 1));
    assign res     = acc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt     <= '0;
            acc     <= '0;
            divisor <= '0;
            div_q   <= 1'b0;
            neg_lo  <= 1'b0;
            neg_hi  <= 1'b0;
        end else if (load) begin
            cnt     <= '0;
            acc     <= {{W{1'b0}}, mag_a};
            divisor <= mag_b;
            div_q   <= is_div;
            neg_lo  <= sign_a ^ sign_b;
            neg_hi  <= is_div ? sign_a : (sign_a ^ sign_b);
        end else if (step) begin
            cnt <= cnt + 1'b1;
            if (div_q) begin
                acc <= fits ? {trial, shl[W-1:1], 1'b1} : shl[2*W-1:0];
            end else begin
                acc <= acc[0] ? {add_sum, acc[W-1:1]} : {1'b0, acc[2*W-1:1]};
            end
        end
    end

endmodule

// File: rtl/alu_seq_core.sv
// rtl/alu_seq_core.sv - signed W-bit sequential ALU with start/done handshake and status flags
module alu_seq_core
    import alu_pkg::*;
#(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    output logic [2*W-1:0]   result,
    output logic             done,
    output logic             busy,
    output logic             flag_zero,
    output logic             flag_dz,
    output logic             flag_ovf,
    output logic             flag_ill
);

    state_e         state;
    op_e            op_q;
    logic [W-1:0]   a_q, b_q;
    flags_t         flg_q, flg_nxt;
    logic [2*W-1:0] res_nxt;
    logic [W:0]     sum_w;
    logic [W-1:0]   quo, rem;

    logic           eng_load, eng_fin, eng_neg_lo, eng_neg_hi;
    logic [W-1:0]   mag_a, mag_b;
    logic [2*W-1:0] eng_res;
    logic           iter_path;

    assign mag_a     = a_q[W-1] ? (~a_q + 1'b1) : a_q;
    assign mag_b     = b_q[W-1] ? (~b_q + 1'b1) : b_q;
    assign iter_path = (op_q == OP_MUL) || ((op_q == OP_DIV) && (b_q != '0));
    assign eng_load  = (state == ST_EXEC) && iter_path;

    alu_muldiv_iter #(.W(W)) u_iter (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (eng_load),
        .is_div  (op_q == OP_DIV),
        .mag_a   (mag_a),
        .mag_b   (mag_b),
        .sign_a  (a_q[W-1]),
        .sign_b  (b_q[W-1]),
        .step    (state == ST_ITER),
        .fin     (eng_fin),
        .res     (eng_res),
        .neg_lo  (eng_neg_lo),
        .neg_hi  (eng_neg_hi)
    );

    // Operands stay latched until DONE, so the single-cycle ops are evaluated right at the output load.
    always_comb begin
        res_nxt = '0;
        flg_nxt = '0;
        sum_w   = '0;
        quo     = '0;
        rem     = '0;
        case (op_q)
            OP_ADD: begin
                sum_w   = {a_q[W-1], a_q} + {b_q[W-1], b_q};
                res_nxt = {{(W-1){sum_w[W]}}, sum_w};
            end
            OP_SUB: begin
                sum_w   = {a_q[W-1], a_q} - {b_q[W-1], b_q};
                res_nxt = {{(W-1){sum_w[W]}}, sum_w};
            end
            OP_MUL: res_nxt = eng_neg_lo ? (~eng_res + 1'b1) : eng_res;
            OP_DIV: begin
                if (b_q == '0) begin
                    res_nxt    = {a_q, {W{1'b1}}};
                    flg_nxt.dz = 1'b1;
                end else begin
                    quo         = eng_neg_lo ? (~eng_res[W-1:0] + 1'b1) : eng_res[W-1:0];
                    rem         = eng_neg_hi ? (~eng_res[2*W-1:W] + 1'b1) : eng_res[2*W-1:W];
                    res_nxt     = {rem, quo};
                    flg_nxt.ovf = (a_q == {1'b1, {(W-1){1'b0}}}) && (b_q == {W{1'b1}});
                end
            end
            OP_AND: res_nxt = {{W{1'b0}}, a_q & b_q};
            OP_OR:  res_nxt = {{W{1'b0}}, a_q | b_q};
            OP_XOR: res_nxt = {{W{1'b0}}, a_q ^ b_q};
            OP_ILL: flg_nxt.ill = 1'b1;
            default: res_nxt = '0;
        endcase
        flg_nxt.zero = (res_nxt == '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_IDLE;
            op_q   <= OP_ADD;
            a_q    <= '0;
            b_q    <= '0;
            result <= '0;
            done   <= 1'b0;
            busy   <= 1'b0;
            flg_q  <= '{zero: 1'b1, dz: 1'b0, ovf: 1'b0, ill: 1'b0};
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (done) busy <= 1'b0;
                    if (start) begin
                        a_q   <= in_a;
                        b_q   <= in_b;
                        op_q  <= op_e'(op);
                        busy  <= 1'b1;
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: state <= iter_path ? ST_ITER : ST_DONE;
                ST_ITER: if (eng_fin) state <= ST_DONE;
                ST_DONE: begin
                    result <= res_nxt;
                    flg_q  <= flg_nxt;
                    done   <= 1'b1;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign flag_zero = flg_q.zero;
    assign flag_dz   = flg_q.dz;
    assign flag_ovf  = flg_q.ovf;
    assign flag_ill  = flg_q.ill;

endmodule
